fetch_unit: RTL

Instruction-fetch stage of the RISCVCPU pipeline. It sits between the program counter and the multi-cycle instruction memory (imem) on one side and the decode stage on the other. It holds the PC and issues one word request at a time to imem, then waits out the variable memory latency for `mem_valid`. Each returned word is handed to decode on a valid/ready handshake. Branch/jump redirects are absorbed by discarding any in-flight stale response.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Instruction addresses are word aligned; drop the byte-offset bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: keeps the PC, issues one word request at a time
// to a variable-latency imem and hands each word to decode on a valid/ready
// handshake. Redirects discard any response still in flight.
// Optional feature macro: FETCH_PERF_EN adds the perf_wait_cycles port
// (WAIT/DRAIN cycle counter) and the stray-response assertion.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_wait_cycles
`endif
);

    import fetch_pkg::*;

    fetch_state_t state_r;
    fetch_state_t state_nxt_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_nxt_s;
    logic [31:0]  instr_r;
    logic [31:0]  instr_nxt_s;
    logic [31:0]  pc_hold_r;
    logic [31:0]  pc_hold_nxt_s;
    logic [31:0]  redirect_tgt_s;

    assign redirect_tgt_s = word_align(redirect_pc);

    // Next-state and datapath decisions for the fetch sequence.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        instr_nxt_s   = instr_r;
        pc_hold_nxt_s = pc_hold_r;
        case (state_r)
            IDLE: begin
                // The request goes out this cycle; a redirect makes it stale.
                if (redirect_valid) begin
                    pc_nxt_s    = redirect_tgt_s;
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_nxt_s = redirect_tgt_s;
                    if (mem_valid) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end else if (mem_valid) begin
                    instr_nxt_s   = mem_data;
                    pc_hold_nxt_s = pc_r;
                    state_nxt_s   = HOLD;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nxt_s    = redirect_tgt_s;
                    state_nxt_s = IDLE;
                end else if (id_ready) begin
                    pc_nxt_s    = pc_r + INSTR_BYTES;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            DRAIN: begin
                // Stale response is swallowed; later redirects only retarget.
                if (redirect_valid) begin
                    pc_nxt_s = redirect_tgt_s;
                end else begin
                    pc_nxt_s = pc_r;
                end
                if (mem_valid) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            pc_r      <= RESET_PC;
            instr_r   <= NOP_INSTR;
            pc_hold_r <= RESET_PC;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            instr_r   <= instr_nxt_s;
            pc_hold_r <= pc_hold_nxt_s;
        end
    end

    // Outputs come from registered state; reset only masks the request strobe
    // so imem sees nothing while it is itself being reset.
    assign mem_req  = (state_r == IDLE) && !reset;
    assign mem_addr = pc_r;
    assign if_valid = (state_r == HOLD);
    assign if_pc    = (state_r == HOLD) ? pc_hold_r : pc_r;
    assign if_instr = (state_r == HOLD) ? instr_r : NOP_INSTR;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_cnt_r;

    // Saturating count of cycles spent waiting on imem (WAIT or DRAIN).
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_cnt_r <= 32'd0;
        end else if (((state_r == WAIT) || (state_r == DRAIN)) &&
                     (perf_cnt_r != 32'hFFFF_FFFF)) begin
            perf_cnt_r <= perf_cnt_r + 32'd1;
        end else begin
            perf_cnt_r <= perf_cnt_r;
        end
    end

    assign perf_wait_cycles = perf_cnt_r;

    a_no_stray_response: assert property (@(posedge clock) disable iff (reset)
        !(mem_valid && ((state_r == IDLE) || (state_r == HOLD))));
`endif

endmodule
